tpu_sequencer: RTL and testbench

Parametrised system sequencer for the SIZE×SIZE reduced systolic array with its SIZE×CROWS compensation array. It generalises the fixed 8×8 load/pre-load/compute controller: it derives every phase length from SIZE and CROWS, adds a start/done handshake, loops over a runtime tile count, and adds an output-drain phase with column indexing. It sits between the host load logic and the weight, activation and compensation memories, and it drives the accumulators.

---
 rtl/tpu_pkg.sv | 18 +
 rtl/tpu_sequencer_phase_counter.sv | 25 ++
 rtl/tpu_sequencer.sv | 124 ++++++++++++
 tb/tb_tpu_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array sequencer: FSM encoding and compute-phase length.
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_MEM = 3'd1,
        PRELOAD  = 3'd2,
        CAL      = 3'd3,
        DRAIN    = 3'd4,
        FINISH   = 3'd5
    } state_t;

    // Fill (SIZE-1) + skew (2*SIZE-1) + one output cycle.
    function automatic int cal_cycles(input int size);
        return 3 * size - 1;
    endfunction

endpackage

// File: rtl/tpu_sequencer_phase_counter.sv
// Phase counter: restarts from zero on clr, otherwise counts up; tc flags cnt == limit.
// Latency: cnt_nxt is combinational, cnt registers on the falling edge.
// Backpressure: none; the owner decides when to clear.
module phase_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt_nxt,
    output logic         tc
);

    logic [W-1:0] cnt;

    assign cnt_nxt = clr ? '0 : cnt + W'(1);
    assign tc      = (cnt == limit);

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= cnt_nxt;
    end

endmodule

// File: rtl/tpu_sequencer.sv
// Job sequencer for the systolic array: load, preload, compute and drain per tile.
// Latency: SIZE + CAL_CYCLES cycles from load_mem_done to the first out_valid.
// Backpressure: waits in LOAD_MEM for load_mem_done; start is ignored while busy.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int SIZE       = 8,
    parameter int CROWS      = 3,
    parameter int TILE_WIDTH = 4,
    parameter int CAL_CYCLES = cal_cycles(SIZE),
    parameter int CNT_WIDTH  = $clog2(CAL_CYCLES + 1),
    parameter int COL_WIDTH  = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TILE_WIDTH-1:0] num_tiles,
    input  logic                  load_mem_done,
    output logic                  busy,
    output logic                  load_req,
    output logic                  preload_weight,
    output logic                  preload_cweight,
    output logic                  cal,
    output logic                  out_valid,
    output logic [COL_WIDTH-1:0]  out_col,
    output logic [TILE_WIDTH-1:0] tile_idx,
    output logic                  done
);

    state_t                state, state_nxt;
    logic [TILE_WIDTH-1:0] ntiles_q, ntiles_nxt, tile_nxt;
    logic [CNT_WIDTH-1:0]  cnt_limit, cnt_nxt;
    logic                  cnt_clr, cnt_tc, last_tile;

    phase_counter #(.W(CNT_WIDTH)) u_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .limit   (cnt_limit),
        .cnt_nxt (cnt_nxt),
        .tc      (cnt_tc)
    );

    always_comb begin
        cnt_limit = '0;
        case (state)
            PRELOAD, DRAIN: cnt_limit = CNT_WIDTH'(SIZE - 1);
            CAL:            cnt_limit = CNT_WIDTH'(CAL_CYCLES - 1);
            default:        cnt_limit = '0;
        endcase
    end

    // ntiles_q is non-zero whenever DRAIN is reachable, so the subtraction cannot wrap.
    assign last_tile = (tile_idx == ntiles_q - TILE_WIDTH'(1));

    always_comb begin
        state_nxt  = state;
        ntiles_nxt = ntiles_q;
        tile_nxt   = tile_idx;
        cnt_clr    = 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    ntiles_nxt = num_tiles;
                    tile_nxt   = '0;
                    state_nxt  = (num_tiles == '0) ? FINISH : LOAD_MEM;
                end
            end
            LOAD_MEM: begin
                if (load_mem_done) state_nxt = PRELOAD;
            end
            PRELOAD: begin
                if (cnt_tc) state_nxt = CAL;
                else        cnt_clr   = 1'b0;
            end
            CAL: begin
                if (cnt_tc) state_nxt = DRAIN;
                else        cnt_clr   = 1'b0;
            end
            DRAIN: begin
                if (!cnt_tc) begin
                    cnt_clr = 1'b0;
                end else if (last_tile) begin
                    state_nxt = FINISH;
                end else begin
                    tile_nxt  = tile_idx + TILE_WIDTH'(1);
                    state_nxt = LOAD_MEM;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode the next state/count so they line up with the registered state.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            ntiles_q        <= '0;
            tile_idx        <= '0;
            busy            <= 1'b0;
            load_req        <= 1'b0;
            preload_weight  <= 1'b0;
            preload_cweight <= 1'b0;
            cal             <= 1'b0;
            out_valid       <= 1'b0;
            out_col         <= '0;
            done            <= 1'b0;
        end else begin
            state           <= state_nxt;
            ntiles_q        <= ntiles_nxt;
            tile_idx        <= tile_nxt;
            busy            <= (state_nxt != IDLE);
            load_req        <= (state_nxt == LOAD_MEM);
            preload_weight  <= (state_nxt == PRELOAD);
            preload_cweight <= (state_nxt == PRELOAD) && (cnt_nxt < CNT_WIDTH'(CROWS));
            cal             <= (state_nxt == CAL);
            out_valid       <= (state_nxt == DRAIN);
            out_col         <= (state_nxt == DRAIN) ? cnt_nxt[COL_WIDTH-1:0] : '0;
            done            <= (state_nxt == FINISH);
        end
    end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Bench for tpu_sequencer: SIZE=8/CROWS=3 and SIZE=16/CROWS=16 instances against a phase-timeline model.
module tb_tpu_sequencer;

    typedef struct packed {
        logic       busy;
        logic       load_req;
        logic       pw;
        logic       pcw;
        logic       cal;
        logic       ov;
        logic [3:0] col;
        logic [3:0] tile;
        logic       done;
    } out_t;

    typedef struct {
        logic       start;
        logic [3:0] nt;
        logic       ld;
        out_t       exp;
    } rec_t;

    typedef struct {
        int sel; int n; int d;
        int pw; int pcw; int cal; int ov; int lrq; int done;
    } job_t;

    typedef enum {P_IDLE, P_LOAD, P_PRE, P_CAL, P_DRAIN, P_FIN} ph_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, ld8, start16, ld16;
    logic [3:0] nt8, nt16;
    logic       busy8, lr8, pw8, pcw8, cal8, ov8, done8;
    logic [2:0] col8;
    logic [3:0] tile8;
    logic       busy16, lr16, pw16, pcw16, cal16, ov16, done16;
    logic [3:0] col16, tile16;

    always #5 clk = ~clk;

    tpu_sequencer #(.SIZE(8), .CROWS(3), .TILE_WIDTH(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .num_tiles(nt8), .load_mem_done(ld8),
        .busy(busy8), .load_req(lr8), .preload_weight(pw8), .preload_cweight(pcw8),
        .cal(cal8), .out_valid(ov8), .out_col(col8), .tile_idx(tile8), .done(done8)
    );

    tpu_sequencer #(.SIZE(16), .CROWS(16), .TILE_WIDTH(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .num_tiles(nt16), .load_mem_done(ld16),
        .busy(busy16), .load_req(lr16), .preload_weight(pw16), .preload_cweight(pcw16),
        .cal(cal16), .out_valid(ov16), .out_col(col16), .tile_idx(tile16), .done(done16)
    );

    rec_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   s_pw, s_pcw, s_cal, s_ov, s_lrq, s_done;
    logic prev_lr;

    function automatic out_t expect_out(ph_t ph, int idx, int tile, int cr);
        out_t o;
        o          = '0;
        o.busy     = (ph != P_IDLE);
        o.load_req = (ph == P_LOAD);
        o.pw       = (ph == P_PRE);
        o.pcw      = (ph == P_PRE) && (idx < cr);
        o.cal      = (ph == P_CAL);
        o.ov       = (ph == P_DRAIN);
        o.col      = (ph == P_DRAIN) ? 4'(idx) : 4'd0;
        o.tile     = 4'(tile);
        o.done     = (ph == P_FIN);
        return o;
    endfunction

    function automatic void push(logic st, logic ld, out_t e);
        rec_t r;
        r.start = st;
        r.nt    = 4'($urandom_range(0, 15));
        r.ld    = ld;
        r.exp   = e;
        q.push_back(r);
    endfunction

    // Don't-care inputs are randomised: start/num_tiles while busy, load_mem_done outside LOAD_MEM.
    function automatic void push_dc(out_t e);
        push(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), e);
    endfunction

    // d < 0 picks a random load delay per tile.
    function automatic void build(int sel, int n, int d);
        int   sz, cr, cc, dd;
        rec_t r;
        sz = sel ? 16 : 8;
        cr = sel ? 16 : 3;
        cc = 3 * sz - 1;
        r.start = 1'b1;
        r.nt    = 4'(n);
        r.ld    = 1'($urandom_range(0, 1));
        r.exp   = (n == 0) ? expect_out(P_FIN, 0, 0, cr) : expect_out(P_LOAD, 0, 0, cr);
        q.push_back(r);
        if (n == 0) push_dc(expect_out(P_IDLE, 0, 0, cr));
        for (int t = 0; t < n; t++) begin
            dd = (d < 0) ? $urandom_range(0, 3) : d;
            repeat (dd) push(($urandom_range(0, 1) == 1), 1'b0, expect_out(P_LOAD, 0, t, cr));
            push(($urandom_range(0, 1) == 1), 1'b1, expect_out(P_PRE, 0, t, cr));
            for (int i = 1; i < sz; i++) push_dc(expect_out(P_PRE, i, t, cr));
            for (int i = 0; i < cc; i++) push_dc(expect_out(P_CAL, i, t, cr));
            for (int i = 0; i < sz; i++) push_dc(expect_out(P_DRAIN, i, t, cr));
            if (t < n - 1) begin
                push_dc(expect_out(P_LOAD, 0, t + 1, cr));
            end else begin
                push_dc(expect_out(P_FIN, 0, t, cr));
                push_dc(expect_out(P_IDLE, 0, 0, cr));
            end
        end
        repeat (2) push(1'b0, 1'($urandom_range(0, 1)), expect_out(P_IDLE, 0, 0, cr));
    endfunction

    function automatic out_t sample(int sel);
        out_t o;
        if (sel != 0) o = {busy16, lr16, pw16, pcw16, cal16, ov16, col16, tile16, done16};
        else          o = {busy8, lr8, pw8, pcw8, cal8, ov8, {1'b0, col8}, tile8, done8};
        return o;
    endfunction

    task automatic check_int(string nm, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Called at a rising edge; each record is one falling-edge update of the DUT.
    task automatic apply(int sel, int lim, string name);
        out_t got, e;
        for (int i = 0; i < q.size() && i < lim; i++) begin
            if (sel != 0) begin start16 = q[i].start; nt16 = q[i].nt; ld16 = q[i].ld; end
            else          begin start8  = q[i].start; nt8  = q[i].nt; ld8  = q[i].ld; end
            @(negedge clk);
            @(posedge clk);
            got = sample(sel);
            e   = q[i].exp;
            if (!e.busy) begin got.tile = '0; e.tile = '0; end
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL %s step %0d: got %h, expected %h", name, i, got, e);
            end
            s_pw   += int'(got.pw);
            s_pcw  += int'(got.pcw);
            s_cal  += int'(got.cal);
            s_ov   += int'(got.ov);
            s_done += int'(got.done);
            if (got.load_req && !prev_lr) s_lrq++;
            prev_lr = got.load_req;
        end
        start8 = 1'b0; start16 = 1'b0; ld8 = 1'b0; ld16 = 1'b0;
        q.delete();
    endtask

    job_t jobs[6];

    initial begin
        jobs[0] = '{0,  1, 64, 8,   3,   23,  8,   1,  1};
        jobs[1] = '{0,  3,  5, 24,  9,   69,  24,  3,  1};
        jobs[2] = '{0,  0,  0, 0,   0,   0,   0,   0,  1};
        jobs[3] = '{1,  1,  2, 16,  16,  47,  16,  1,  1};
        jobs[4] = '{1,  2,  0, 32,  32,  94,  32,  2,  1};
        jobs[5] = '{0, 15,  0, 120, 45,  345, 120, 15, 1};

        rst = 1'b0;
        start8 = 1'b0; nt8 = '0; ld8 = 1'b0;
        start16 = 1'b0; nt16 = '0; ld16 = 1'b0;
        prev_lr = 1'b0;
        repeat (2) @(posedge clk);
        check_int("reset_outputs_s8", int'(sample(0)), 0);
        check_int("reset_outputs_s16", int'(sample(1)), 0);
        rst = 1'b1;

        for (int j = 0; j < 6; j++) begin
            s_pw = 0; s_pcw = 0; s_cal = 0; s_ov = 0; s_lrq = 0; s_done = 0;
            prev_lr = 1'b0;
            build(jobs[j].sel, jobs[j].n, jobs[j].d);
            apply(jobs[j].sel, 1 << 30, "job_trace");
            check_int("preload_weight_cycles", s_pw, jobs[j].pw);
            check_int("preload_cweight_cycles", s_pcw, jobs[j].pcw);
            check_int("cal_cycles", s_cal, jobs[j].cal);
            check_int("out_valid_cycles", s_ov, jobs[j].ov);
            check_int("load_req_rises", s_lrq, jobs[j].lrq);
            check_int("done_pulses", s_done, jobs[j].done);
        end

        // Reset while CAL has cnt == 10: start, 1 load edge, 8 preload, 11 cal updates.
        build(0, 1, 0);
        apply(0, 20, "pre_reset");
        check_int("cal_before_reset", int'(cal8), 1);
        #2 rst = 1'b0;
        #1 check_int("async_reset_outputs", int'(sample(0)), 0);
        @(posedge clk);
        rst = 1'b1;
        push(1'b0, 1'b0, expect_out(P_IDLE, 0, 0, 3));
        push(1'b0, 1'b1, expect_out(P_IDLE, 0, 0, 3));
        apply(0, 1 << 30, "idle_after_reset");
        s_done = 0;
        build(0, 2, -1);
        apply(0, 1 << 30, "rerun_after_reset");
        check_int("rerun_done_pulses", s_done, 1);

        for (int k = 0; k < 8; k++) begin
            int sel;
            sel = $urandom_range(0, 1);
            build(sel, $urandom_range(0, 4), -1);
            apply(sel, 1 << 30, "random_job");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
